// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl
// Time-multiplexed scan controller for a bank of seven-segment digits that
// share one hex segment decoder. A slot counter walks a digit index at a
// fixed rate. Each slot opens with a blanking gap (all digits off, decoder
// input already switched) so the decoder settles without ghosting. The slot
// then lights the selected digit. Display data is double-buffered: a load
// lands in a pending copy and is promoted to the shadow copy only at the end
// of a frame, so a frame never mixes old and new data.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   value      in   display nibbles, digit i = value[4i+3:4i]
//   dp_in      in   decimal point request per digit
//   en_in      in   digit enable per digit
//   load       in   one-cycle strobe capturing value/dp_in/en_in
//   num        out  nibble for the shared segment decoder
//   an         out  digit select, one digit active or all inactive
//   dp         out  decimal point for the lit digit
//   upd_pend   out  captured update waiting for the frame boundary
//   frame_done out  one-cycle pulse on the last cycle of each frame
//
// an/dp polarity is selected by INV (1 = active-low). Internal logic is
// active-high and INV is applied only at the output registers.

module sseg_scan_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 500,
    parameter bit          LZS      = 1'b0,
    parameter bit          INV      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    input  logic                  load,
    output logic [3:0]            num,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  upd_pend,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{INV}};

    // Scan position
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic              frame_end_c;

    // Shadow (displayed) and pending (captured) display data
    logic [VAL_W-1:0]  sh_val;
    logic [DIGITS-1:0] sh_dp;
    logic [DIGITS-1:0] sh_en;
    logic [VAL_W-1:0]  sh_val_nxt;
    logic [DIGITS-1:0] sh_dp_nxt;
    logic [DIGITS-1:0] sh_en_nxt;
    logic [VAL_W-1:0]  pd_val;
    logic [DIGITS-1:0] pd_dp;
    logic [DIGITS-1:0] pd_en;
    logic [VAL_W-1:0]  pd_val_nxt;
    logic [DIGITS-1:0] pd_dp_nxt;
    logic [DIGITS-1:0] pd_en_nxt;
    logic              pend_nxt;

    // Output pre-register values (active-high)
    logic              lit_c;
    logic [DIGITS-1:0] supp;
    logic              zero_run;
    logic [DIGITS-1:0] sel;
    logic [3:0]        nib;
    logic              dig_en;
    logic              dig_dp;
    logic              dig_supp;
    logic              visible;
    logic [DIGITS-1:0] an_act;
    logic              dp_act;
    logic              frame_done_nxt;

    // Slot counter and digit index; frame ends on the last cycle of the last digit
    always_comb begin
        cnt_nxt     = cnt + CNT_W'(1);
        idx_nxt     = idx;
        frame_end_c = (cnt == CNT_LAST) && (idx == IDX_LAST);
        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (idx == IDX_LAST) begin
                idx_nxt = '0;
            end else begin
                idx_nxt = idx + IDX_W'(1);
            end
        end
    end

    // Update handshake: a load in the frame-end cycle bypasses pending and
    // goes straight to shadow; otherwise pending is promoted at frame end.
    always_comb begin
        sh_val_nxt = sh_val;
        sh_dp_nxt  = sh_dp;
        sh_en_nxt  = sh_en;
        pd_val_nxt = pd_val;
        pd_dp_nxt  = pd_dp;
        pd_en_nxt  = pd_en;
        pend_nxt   = upd_pend;
        if (frame_end_c) begin
            pend_nxt = 1'b0;
            if (load) begin
                sh_val_nxt = value;
                sh_dp_nxt  = dp_in;
                sh_en_nxt  = en_in;
            end else if (upd_pend) begin
                sh_val_nxt = pd_val;
                sh_dp_nxt  = pd_dp;
                sh_en_nxt  = pd_en;
            end
        end else if (load) begin
            pd_val_nxt = value;
            pd_dp_nxt  = dp_in;
            pd_en_nxt  = en_in;
            pend_nxt   = 1'b1;
        end
    end

    // Lit phase of the slot, evaluated for the cycle being registered into
    generate
        if (BLANK == 0) begin : g_no_blank
            assign lit_c = 1'b1;
        end else begin : g_blank
            assign lit_c = (cnt_nxt >= CNT_W'(BLANK));
        end
    endgenerate

    // Leading-zero suppression: a digit goes dark when it and every digit
    // above it carry a zero nibble and no decimal point. Digit 0 always shows.
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run && (sh_val_nxt[4*i +: 4] == 4'h0) && !sh_dp_nxt[i];
            supp[i]  = LZS && (i != 0) && zero_run;
        end
    end

    // Select the digit at the upcoming scan position and form active-high outputs
    always_comb begin
        sel      = '0;
        nib      = 4'h0;
        dig_en   = 1'b0;
        dig_dp   = 1'b0;
        dig_supp = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                sel[i]   = 1'b1;
                nib      = sh_val_nxt[4*i +: 4];
                dig_en   = sh_en_nxt[i];
                dig_dp   = sh_dp_nxt[i];
                dig_supp = supp[i];
            end
        end
        visible        = dig_en && !dig_supp;
        an_act         = (lit_c && visible) ? sel : '0;
        dp_act         = lit_c && visible && dig_dp;
        frame_done_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            pd_val     <= '0;
            pd_dp      <= '0;
            pd_en      <= '0;
            upd_pend   <= 1'b0;
            frame_done <= 1'b0;
            num        <= 4'h0;
            an         <= AN_OFF;
            dp         <= INV;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            sh_val     <= sh_val_nxt;
            sh_dp      <= sh_dp_nxt;
            sh_en      <= sh_en_nxt;
            pd_val     <= pd_val_nxt;
            pd_dp      <= pd_dp_nxt;
            pd_en      <= pd_en_nxt;
            upd_pend   <= pend_nxt;
            frame_done <= frame_done_nxt;
            num        <= nib;
            an         <= an_act ^ AN_OFF;
            dp         <= dp_act ^ INV;
        end
    end

endmodule
